pipelined_add_sub: RTL
======================

// Module: pipelined_add_sub
// PURPOSE
//  Parametrised, pipelined two's-complement adder/subtractor for the ALU/EX datapath.
//  Splits a WIDTH-bit operation into STAGES ripple-carry chunks, one chunk per cycle.
//  The carry is registered between chunks, so the cycle time is set by one chunk, not the full width.
//  Produces sum, carry-out, signed overflow and zero flags with a valid tag.
//  Supports stall and flush from the hazard unit.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be divisible by STAGES
//  STAGES  4   pipeline depth = number of carry chunks (1..WIDTH); chunk width CW = WIDTH/STAGES
// PORTS
//  i_CLK    in   1      rising-edge clock
//  i_RST    in   1      synchronous, active-high reset
//  i_STALL  in   1      1 = hold every pipeline register (data and valid)
//  i_FLUSH  in   1      1 = clear all valid bits in flight (synchronous)
//  i_VALID  in   1      operands/op valid this cycle
//  i_SUB    in   1      0 = A+B, 1 = A-B (A + ~B + 1)
//  i_A      in   WIDTH  operand A
//  i_B      in   WIDTH  operand B
//  o_S      out  WIDTH  result
//  o_C      out  1      carry-out of MSB (for SUB: 1 = no borrow)
//  o_V      out  1      signed overflow = carry into MSB XOR carry out of MSB
//  o_Z      out  1      1 when o_S == 0
//  o_VALID  out  1      o_S/o_C/o_V/o_Z are a completed result
// BEHAVIOUR
//  - Clock is i_CLK; reset i_RST is synchronous and active-high.
//    On reset, every register is 0, so o_S=0, o_C=0, o_V=0, o_Z=0 and o_VALID=0 on the next edge.
//  - Priority at each edge: i_RST > i_FLUSH > i_STALL > normal advance.
//  - Acceptance: an op is taken only when i_VALID=1 and i_STALL=0. i_VALID=0 inserts a bubble.
//  - Stage k (0..STAGES-1) adds bits [k*CW +: CW] of A and B' (B' = i_SUB ? ~B : B) plus carry c_k.
//    - c_0 = i_SUB.
//    - The chunk sum is registered, and its carry-out becomes c_{k+1} for stage k+1.
//  - Skew/deskew:
//    - Upper operand slices are delayed so they meet their carry in stage k.
//    - Lower result slices are delayed so all slices of one op reach the outputs together.
//    - Ops never mix slices.
//  - Latency: exactly STAGES cycles from acceptance to o_VALID=1, with zero stalls.
//    Throughput: 1 op per cycle.
//  - Flags are registered with the final stage and appear together with o_S.
//    - o_V uses the carry into bit WIDTH-1 and the carry out of bit WIDTH-1.
//    - o_Z is the NOR of the full assembled result.
//  - Stall: all data and valid registers hold. Outputs stay stable, and o_VALID keeps its value.
//    An input presented during a stall is not accepted.
//  - Flush: all valid bits go to 0 on the next edge, including the input-side capture.
//    - Data registers may keep stale values; only valid carries meaning.
//    - A flush during a stall still clears valid.
//  - Reset mid-operation: in-flight ops are dropped with no partial result, and o_VALID=0 next cycle.
//  - STAGES=1: a single registered full-width ripple add with latency 1.
//  - Bubbles: o_VALID=0 in the bubble's output cycle. Data outputs in that cycle are don't-care.
//  - Wrap-around: the result is modulo 2^WIDTH. Overflow is reported only via o_C and o_V.
// STRUCTURE
//  - Shared package alu_pkg holds:
//    - localparam ALU_OP_ADD=1'b0, ALU_OP_SUB=1'b1
//    - function chunk_w(WIDTH,STAGES)
//    - WIDTH%STAGES elaboration check macro
//  - Sub-module add_chunk: CW-bit combinational ripple-carry adder with inputs a, b, cin.
//    It outputs s, cout and c_msb_in (the carry into its top bit, used by the last stage for o_V).
//    It is instantiated STAGES times in a generate loop.
//  - Top level: generate loop of stage registers (valid, carry, skewed operands, deskewed sums) plus flag logic.
// TESTING
//  1. Reset: assert i_RST for 2 cycles while i_VALID=1.
//     -> o_VALID=0 and all outputs 0 for the cycle after release.
//  2. Add, WIDTH=32, STAGES=4: A=0x0000_FFFF, B=0x0000_0001, SUB=0.
//     -> after exactly 4 cycles: o_S=0x0001_0000, C=0, V=0, Z=0, VALID=1.
//     The cross-chunk carry must propagate.
//  3. Sub and overflow, back-to-back in consecutive cycles:
//     - (0x8000_0000 - 1) -> S=0x7FFF_FFFF, C=1, V=1
//     - (5 - 5) -> S=0, C=1, Z=1
//     - (0 - 1) -> S=0xFFFF_FFFF, C=0, V=0
//     Results appear on 3 consecutive cycles.
//  4. Stall: stall 3 cycles while an op is in stage 2.
//     -> result is delayed by exactly 3 cycles and outputs are frozen during the stall.
//     An input offered during the stall is not accepted.
//  5. Flush: 3 ops in flight, then assert i_FLUSH for 1 cycle.
//     -> o_VALID stays 0 for the next 4 cycles.
//     An op issued in the cycle after the flush completes normally.
//  6. Randomised against a golden model: 10k ops with random stall/flush/bubbles.
//     Run with WIDTH/STAGES = 32/4, 32/1, 16/16 and 8/2.
//     -> every valid output matches {C,S} = A ± B, and V and Z match the golden model.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, chunk sizing helper and the
// elaboration-time divisibility check used by the pipelined adder.
`ifndef ALU_PKG_SV
`define ALU_PKG_SV

// Stops elaboration when WIDTH cannot be split evenly into STAGES chunks.
`define ALU_CHECK_DIV(W, S) \
  if (((W) % (S)) != 0) begin : g_bad_div \
    $error("pipelined_add_sub: WIDTH must be divisible by STAGES"); \
  end

package alu_pkg;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

  function automatic int unsigned chunk_w(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

`endif

// File: rtl/add_chunk.sv
// CW-bit combinational ripple adder slice; also exposes the carry into its
// top bit so the most significant slice can derive signed overflow.
module add_chunk #(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] s,
  output logic          cout,
  output logic          c_msb_in
);

  logic [CW:0] sum_c;

  assign sum_c    = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  assign s        = sum_c[CW-1:0];
  assign cout     = sum_c[CW];
  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
  assign c_msb_in = s[CW-1] ^ a[CW-1] ^ b[CW-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: one CW-bit carry chunk per
// stage, operands skewed in and sums deskewed out, flags on the last stage.
module pipelined_add_sub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_STALL,
  input  logic             i_FLUSH,
  input  logic             i_VALID,
  input  logic             i_SUB,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic [WIDTH-1:0] o_S,
  output logic             o_C,
  output logic             o_V,
  output logic             o_Z,
  output logic             o_VALID
);

  localparam int unsigned CW = chunk_w(WIDTH, STAGES);

  `ALU_CHECK_DIV(WIDTH, STAGES)

  logic ovf_d, ovf_q;
  logic zero_d, zero_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned IN_W = WIDTH - k * CW;
    localparam int unsigned LO_W = (k + 1) * CW;

    logic [IN_W-1:0] a_in;
    logic [IN_W-1:0] b_in;
    logic            cin;
    logic            vin;
    logic [CW-1:0]   s_c;
    logic            cout_c;
    logic [LO_W-1:0] s_d;
    logic [LO_W-1:0] s_q;
    logic            v_q;
    logic            c_q;

    if (k == 0) begin : g_head
      assign a_in = i_A;
      assign b_in = (i_SUB == ALU_OP_ADD) ? i_B : ~i_B;
      assign cin  = (i_SUB == ALU_OP_SUB);
      assign vin  = i_VALID;
      assign s_d  = s_c;
    end else begin : g_body
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign cin  = g_stage[k-1].c_q;
      assign vin  = g_stage[k-1].v_q;
      assign s_d  = {s_c, g_stage[k-1].s_q};
    end

    if (k == STAGES - 1) begin : g_tail
      logic cmsb_c;

      add_chunk #(.CW(CW)) u_chunk (
        .a        (a_in[CW-1:0]),
        .b        (b_in[CW-1:0]),
        .cin      (cin),
        .s        (s_c),
        .cout     (cout_c),
        .c_msb_in (cmsb_c)
      );

      assign ovf_d  = cout_c ^ cmsb_c;
      assign zero_d = ~|s_d;
    end else begin : g_fwd
      logic              cmsb_unused;
      logic [IN_W-CW-1:0] a_q;
      logic [IN_W-CW-1:0] b_q;

      add_chunk #(.CW(CW)) u_chunk (
        .a        (a_in[CW-1:0]),
        .b        (b_in[CW-1:0]),
        .cin      (cin),
        .s        (s_c),
        .cout     (cout_c),
        .c_msb_in (cmsb_unused)
      );

      // Upper operand slices ride along until their chunk's carry arrives.
      always_ff @(posedge i_CLK) begin
        if (i_RST) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!i_STALL) begin
          a_q <= a_in[IN_W-1:CW];
          b_q <= b_in[IN_W-1:CW];
        end
      end
    end

    always_ff @(posedge i_CLK) begin
      if (i_RST) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else begin
        if (i_FLUSH) begin
          v_q <= 1'b0;
        end else if (!i_STALL) begin
          v_q <= vin;
        end
        if (!i_STALL) begin
          c_q <= cout_c;
          s_q <= s_d;
        end
      end
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (!i_STALL) begin
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign o_S     = g_stage[STAGES-1].s_q;
  assign o_C     = g_stage[STAGES-1].c_q;
  assign o_VALID = g_stage[STAGES-1].v_q;
  assign o_V     = ovf_q;
  assign o_Z     = zero_q;

endmodule
